// File: rtl/rotary_quad_gen.sv
// Quadrature transmitter: drives rot_a/rot_b through a Gray-coded four-phase
// cycle per detent step, for a commanded step count and direction.
module rotary_quad_gen #(
  parameter int PHASE_CYCLES = 16,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  output logic               rot_a,
  output logic               rot_b,
  output logic               busy,
  output logic               step_done,
  output logic               done,
  output logic [COUNT_W-1:0] steps_left
);

  localparam int TW = $clog2(PHASE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    P4   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          dir;

  // Handshake: a command transfers on any posedge where cmd_valid and cmd_ready
  // are both high; cmd_ready is high exactly while the FSM sits in IDLE.
  assign busy      = (state != IDLE);
  assign cmd_ready = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      dir        <= 1'b0;
      rot_a      <= 1'b0;
      rot_b      <= 1'b0;
      step_done  <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else begin
      step_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir        <= cmd_dir;
            steps_left <= cmd_steps;
            timer      <= '0;
            if (cmd_steps != '0) begin
              state          <= P1;
              {rot_a, rot_b} <= cmd_dir ? 2'b01 : 2'b10;
            end else begin
              done <= 1'b1;
            end
          end
        end
        P1, P2, P3, P4: begin
          if (timer == T_LAST) begin
            timer <= '0;
            case (state)
              P1: begin
                state          <= P2;
                {rot_a, rot_b} <= 2'b11;
              end
              P2: begin
                state          <= P3;
                {rot_a, rot_b} <= dir ? 2'b10 : 2'b01;
              end
              P3: begin
                state          <= P4;
                {rot_a, rot_b} <= 2'b00;
              end
              default: begin
                // End of a full step; steps_left is >=1 here so it cannot underflow.
                steps_left <= steps_left - ONE;
                step_done  <= 1'b1;
                if (steps_left == ONE) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end else begin
                  state          <= P1;
                  {rot_a, rot_b} <= dir ? 2'b01 : 2'b10;
                end
              end
            endcase
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Bench for rotary_quad_gen: expected output events are queued at command issue
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_rotary_quad_gen;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = '0;
  logic       rot_a, rot_b, busy, step_done, done;
  logic [7:0] steps_left;

  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [3:0] b_steps = '0;
  logic       b_rot_a, b_rot_b, b_busy, b_step_done, b_done;
  logic [3:0] b_steps_left;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] ecyc;
    logic [1:0]  rot;
    logic        sd;
    logic        dn;
    logic [7:0]  sl;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] sl_q[$];
  logic [1:0] prev_rot = 2'b00;
  logic [1:0] b_prev = 2'b00;
  int         b_tog = 0;
  int         b_done_cnt = 0;
  int         b_exp_done = 0;

  rotary_quad_gen #(.PHASE_CYCLES(P), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .rot_a(rot_a), .rot_b(rot_b),
    .busy(busy), .step_done(step_done), .done(done), .steps_left(steps_left)
  );

  rotary_quad_gen #(.PHASE_CYCLES(1), .COUNT_W(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_dir(1'b1), .cmd_steps(b_steps), .rot_a(b_rot_a), .rot_b(b_rot_b),
    .busy(b_busy), .step_done(b_step_done), .done(b_done), .steps_left(b_steps_left)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event list for one command; events past 'stop' are not queued.
  task automatic push_expect(input int a, input logic d, input int n, input int stop);
    ev_t e;
    int  t;
    if (n == 0) begin
      e = '{ecyc: 32'(a), rot: 2'b00, sd: 1'b0, dn: 1'b1, sl: 8'd0};
      exp_q.push_back(e);
      return;
    end
    for (int s = 0; s < n; s++) begin
      for (int ph = 0; ph < 4; ph++) begin
        t = a + (4 * s + ph) * P;
        if (t > stop) return;
        e.ecyc = 32'(t);
        case (ph)
          0:       e.rot = d ? 2'b01 : 2'b10;
          1:       e.rot = 2'b11;
          2:       e.rot = d ? 2'b10 : 2'b01;
          default: e.rot = 2'b00;
        endcase
        e.sd = (ph == 0 && s > 0);
        e.dn = 1'b0;
        e.sl = 8'(n - s);
        exp_q.push_back(e);
      end
    end
    t = a + 4 * n * P;
    if (t <= stop) begin
      e = '{ecyc: 32'(t), rot: 2'b00, sd: 1'b1, dn: 1'b1, sl: 8'd0};
      exp_q.push_back(e);
    end
  endtask

  // driver tasks
  task automatic issue(input logic d, input int n, input int stop, output int a);
    int g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = 8'(n);
    a = cyc + 1;
    push_expect(a, d, n, stop);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("wait_cyc_reached", 64'(cyc), 64'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rot"}, {62'd0, rot_a, rot_b}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
    check({tag, "_done"}, {62'd0, done, step_done}, 64'd0);
    check({tag, "_steps_left"}, {56'd0, steps_left}, 64'd0);
  endtask

  // scoreboard monitor for the main instance
  always @(negedge clk) begin
    logic [1:0] cur;
    ev_t        act, e;
    cur = {rot_a, rot_b};
    if (rst_n) begin
      check("ready_is_not_busy", {63'd0, cmd_ready}, {63'd0, ~busy});
      if (cur != prev_rot || step_done || done) begin
        if (cur != prev_rot)
          check("gray_single_bit", 64'($countones(cur ^ prev_rot)), 64'd1);
        act = '{ecyc: 32'(cyc), rot: cur, sd: step_done, dn: done, sl: steps_left};
        if (exp_q.size() == 0) begin
          check("unexpected_event", {20'd0, act}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event{cyc,ab,sd,dn,left}", {20'd0, act}, {20'd0, e});
        end
      end
    end
    prev_rot = cur;
  end

  // monitor for the PHASE_CYCLES=1 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if ({b_rot_a, b_rot_b} != b_prev) b_tog++;
      if (b_step_done) begin
        if (sl_q.size() == 0) check("fast_unexpected_step", {60'd0, b_steps_left}, 64'hf);
        else check("fast_steps_left", {60'd0, b_steps_left}, {60'd0, sl_q.pop_front()});
      end
      if (b_done) begin
        b_done_cnt++;
        check("fast_done_cyc", 64'(cyc), 64'(b_exp_done));
      end
    end
    b_prev = {b_rot_a, b_rot_b};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, g;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1 and 2: two steps each direction
    issue(1'b1, 2, 1 << 30, a);
    drain();
    issue(1'b0, 2, 1 << 30, a);
    drain();

    // 3: zero steps, stays idle
    issue(1'b1, 0, 1 << 30, a);
    check("zero_busy", {63'd0, busy}, 64'd0);
    check("zero_rot", {62'd0, rot_a, rot_b}, 64'd0);
    drain();

    // 4: cmd_valid held through a 3-step command; second accepted in the done cycle
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd3;
    a = cyc + 1;
    push_expect(a, 1'b1, 3, 1 << 30);
    @(negedge clk);
    cmd_dir   = 1'b0;
    cmd_steps = 8'd2;
    a2 = a + 12 * P + 1;
    push_expect(a2, 1'b0, 2, 1 << 30);
    wait_cyc(a2);
    cmd_valid = 1'b0;
    drain();

    // 5: reset in mid-P2 of step 3 of 5
    issue(1'b1, 5, 0, a);
    exp_q.delete();
    push_expect(a, 1'b1, 5, a + 9 * P);
    wait_cyc(a + 9 * P + 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midstep_reset");
    check("reset_queue_consumed", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    issue(1'b0, 1, 1 << 30, a);
    drain();

    // 6: PHASE_CYCLES=1, 15 steps, no wrap
    @(negedge clk);
    b_valid = 1'b1;
    b_steps = 4'd15;
    a = cyc + 1;
    b_exp_done = a + 60;
    for (int i = 14; i >= 0; i--) sl_q.push_back(4'(i));
    @(negedge clk);
    b_valid = 1'b0;
    check("fast_initial_left", {60'd0, b_steps_left}, 64'd15);
    g = 0;
    while (b_done_cnt == 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    check("fast_done_count", 64'(b_done_cnt), 64'd1);
    check("fast_toggles", 64'(b_tog), 64'd60);
    check("fast_left_queue_empty", 64'(sl_q.size()), 64'd0);
    check("fast_final_left", {60'd0, b_steps_left}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
